vga_draw_arbiter: RTL and testbench
===================================

# vga_draw_arbiter

Merges the pixel-write streams of all drawing agents into the single write port of the VGA adapter. It sits directly downstream of `player_object`, which has no backpressure, and of two stallable drawers (obstacle drawer, HUD/score drawer). The player stream always wins. The stallable clients share the remaining cycles round-robin through a valid/ready handshake. Off-screen writes are dropped and counted.

## Interface
Parameters:
- nX, 10, x-coordinate width
- nY, 9, y-coordinate width
- COLOR_DEPTH, 9, colour width (3:3:3)
- XSCREEN, 640, visible width; writes with x ≥ XSCREEN are clipped
- YSCREEN, 480, visible height; writes with y ≥ YSCREEN are clipped

Ports:
- Clock  in  1  system clock; all logic on its rising edge
- Resetn  in  1  reset, synchronous, active-low
- p_x / p_y / p_color  in  nX / nY / COLOR_DEPTH  player pixel
- p_write  in  1  player write strobe; no backpressure, never stalled
- a_x / a_y / a_color  in  nX / nY / COLOR_DEPTH  client A pixel (obstacles)
- a_valid  in  1  client A request
- a_ready  out  1  client A pixel accepted this cycle
- b_x / b_y / b_color / b_valid / b_ready  same as A  client B (HUD)
- VGA_x / VGA_y / VGA_color  out  nX / nY / COLOR_DEPTH  registered write to the adapter
- VGA_write  out  1  registered write strobe
- drop_count  out  16  saturating count of clipped writes

## Operation
- Source selection, every cycle:
  - p_write=1: the player is selected. a_ready=b_ready=0.
  - Otherwise, exactly one client valid: that client is selected.
  - Otherwise, both valid: the client not in `last_served` is selected.
- Handshake:
  - a_ready and b_ready are combinational from p_write, a_valid, b_valid and last_served.
  - A transfer occurs when valid && ready.
  - A client holds its x/y/color stable while valid && !ready. Dropping valid without a transfer is allowed.
- `last_served` (1 bit) updates only on a client transfer. Player writes do not change it.
- Clipping:
  - The selected write is in range when x < XSCREEN && y < YSCREEN.
  - Out of range: the write is still consumed (ready asserted for clients), VGA_write=0 next cycle, and drop_count increments, saturating at 16'hFFFF.
- When nothing is selected, VGA_write=0 next cycle and VGA_x/VGA_y/VGA_color hold their last values.
- Reset:
  - All outputs go to 0 and drop_count to 0.
  - last_served resets to B, so A wins the first tie.
  - A handshake in progress when reset asserts is discarded. Ready outputs are forced low while Resetn=0.

## Timing
- Latency is 1 cycle: a write selected in cycle N appears on VGA_* with VGA_write=1 in cycle N+1.
- Throughput is 1 pixel per cycle. A continuous player burst (3600 cycles for a 60×60 sprite) starves both clients for its full length.
- Round-robin fairness: with both clients valid and the player idle, transfers alternate A, B, A, B, …
- When p_write and a client valid rise in the same cycle, the player wins. The client transfers in the first cycle after p_write falls.
- Each accepted write affects drop_count or VGA_write exactly once. No write is duplicated or lost except by clipping.
- The only state is last_served, the output registers and drop_count. There is no FSM beyond the round-robin pointer, and no buffering.

## Structure
- Shared package/include `vga_pkg`: nX, nY, COLOR_DEPTH, XSCREEN, YSCREEN, ERASE_COLOR (9'b000_000_000), and the lane geometry constants (NUM_LANES, LANE_WIDTH, LANE_START_X). The player, obstacle and HUD drawers already duplicate these constants and move to the package.
- Sub-module `rr_arbiter2`:
  - Inputs: req[1:0], inhibit, advance.
  - Outputs: one-hot gnt[1:0].
  - Owns last_served.
- The top level does the player override, clipping, output register and drop counter.

## Test plan
- Reset with a_valid=1 → VGA_write=0, a_ready=0 while Resetn=0. After release, A transfers in the first cycle; VGA_write=1 one cycle later.
- p_write=1 for 3600 cycles at (150,360) with a_valid=b_valid=1 → a_ready=b_ready=0 throughout. VGA_* mirror the player stream delayed 1 cycle. Clients resume the cycle after p_write falls.
- A and B both valid continuously for 8 cycles, player idle → grant order A,B,A,B,A,B,A,B. Each client sees 4 transfers with the correct colours at the output.
- Client A writes x=640,y=10 then x=10,y=480 → both accepted (a_ready=1), VGA_write stays 0, drop_count=2.
- drop_count preloaded near saturation by 65540 clipped writes → drop_count holds at 16'hFFFF.
- Client B held valid with changing data while stalled by the player → only the value present at the transfer cycle reaches VGA_color.

Source files
------------

// File: rtl/vga_pkg.sv
// Screen geometry, colour format and lane layout shared by all drawers
// and by the VGA write arbiter.
package vga_pkg;

    localparam int nX          = 10;
    localparam int nY          = 9;
    localparam int COLOR_DEPTH = 9;
    localparam int XSCREEN     = 640;
    localparam int YSCREEN     = 480;

    localparam logic [COLOR_DEPTH-1:0] ERASE_COLOR = 9'b000_000_000;

    localparam int NUM_LANES    = 3;
    localparam int LANE_WIDTH   = 120;
    localparam int LANE_START_X = 140;

    typedef enum logic {
        SRV_A = 1'b0,
        SRV_B = 1'b1
    } served_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer records the last client that
// completed a transfer and only moves when advance is asserted.
module rr_arbiter2
    import vga_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [1:0] req,
    input  logic       inhibit,
    input  logic       advance,
    output logic [1:0] gnt
);

    served_e last_served_q;
    served_e last_served_d;

    always_comb begin
        gnt           = 2'b00;
        last_served_d = last_served_q;
        if (!inhibit) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_served_q == SRV_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (advance && (gnt != 2'b00)) begin
            last_served_d = gnt[1] ? SRV_B : SRV_A;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            last_served_q <= SRV_B;
        end else begin
            last_served_q <= last_served_d;
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Merges the player stream (never stalled) and two handshaked drawers
// into one registered VGA write port, clipping off-screen pixels.
module vga_draw_arbiter
    import vga_pkg::*;
#(
    parameter int nX          = vga_pkg::nX,
    parameter int nY          = vga_pkg::nY,
    parameter int COLOR_DEPTH = vga_pkg::COLOR_DEPTH,
    parameter int XSCREEN     = vga_pkg::XSCREEN,
    parameter int YSCREEN     = vga_pkg::YSCREEN
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [nX-1:0]          p_x,
    input  logic [nY-1:0]          p_y,
    input  logic [COLOR_DEPTH-1:0] p_color,
    input  logic                   p_write,
    input  logic [nX-1:0]          a_x,
    input  logic [nY-1:0]          a_y,
    input  logic [COLOR_DEPTH-1:0] a_color,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [nX-1:0]          b_x,
    input  logic [nY-1:0]          b_y,
    input  logic [COLOR_DEPTH-1:0] b_color,
    input  logic                   b_valid,
    output logic                   b_ready,
    output logic [nX-1:0]          VGA_x,
    output logic [nY-1:0]          VGA_y,
    output logic [COLOR_DEPTH-1:0] VGA_color,
    output logic                   VGA_write,
    output logic [15:0]            drop_count
);

    logic [1:0] gnt;
    logic       inhibit;
    logic       advance;

    logic                   sel_valid;
    logic [nX-1:0]          sel_x;
    logic [nY-1:0]          sel_y;
    logic [COLOR_DEPTH-1:0] sel_color;
    logic                   in_range;

    logic [nX-1:0]          vga_x_q, vga_x_d;
    logic [nY-1:0]          vga_y_q, vga_y_d;
    logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
    logic                   vga_write_q, vga_write_d;
    logic [15:0]            drop_count_q, drop_count_d;

    // Reset also inhibits so a pending handshake is never acknowledged.
    assign inhibit = p_write | ~Resetn;
    assign advance = (a_valid & gnt[0]) | (b_valid & gnt[1]);
    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    rr_arbiter2 u_rr (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .req     ({b_valid, a_valid}),
        .inhibit (inhibit),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        sel_valid = 1'b1;
        sel_x     = p_x;
        sel_y     = p_y;
        sel_color = p_color;
        unique case (1'b1)
            p_write: begin
                sel_x     = p_x;
                sel_y     = p_y;
                sel_color = p_color;
            end
            gnt[0]: begin
                sel_x     = a_x;
                sel_y     = a_y;
                sel_color = a_color;
            end
            gnt[1]: begin
                sel_x     = b_x;
                sel_y     = b_y;
                sel_color = b_color;
            end
            default: sel_valid = 1'b0;
        endcase
    end

    assign in_range = ({1'b0, sel_x} < XSCREEN[nX:0])
                   && ({1'b0, sel_y} < YSCREEN[nY:0]);

    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_color_d  = vga_color_q;
        vga_write_d  = 1'b0;
        drop_count_d = drop_count_q;
        if (sel_valid && in_range) begin
            vga_x_d     = sel_x;
            vga_y_d     = sel_y;
            vga_color_d = sel_color;
            vga_write_d = 1'b1;
        end
        if (sel_valid && !in_range && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
            vga_write_q  <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_color_q  <= vga_color_d;
            vga_write_q  <= vga_write_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign VGA_x      = vga_x_q;
    assign VGA_y      = vga_y_q;
    assign VGA_color  = vga_color_q;
    assign VGA_write  = vga_write_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: reset, player override, fairness,
// clipping, drop-count saturation and reset during a pending request.
module tb_vga_draw_arbiter;

    logic       Clock;
    logic       Resetn;
    logic [9:0] p_x, a_x, b_x, VGA_x;
    logic [8:0] p_y, a_y, b_y, VGA_y;
    logic [8:0] p_color, a_color, b_color, VGA_color;
    logic       p_write, a_valid, b_valid;
    logic       a_ready, b_ready, VGA_write;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_a   = 0;
    int n_b   = 0;
    logic [8:0] col;

    vga_draw_arbiter dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .p_x        (p_x),
        .p_y        (p_y),
        .p_color    (p_color),
        .p_write    (p_write),
        .a_x        (a_x),
        .a_y        (a_y),
        .a_color    (a_color),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_x        (b_x),
        .b_y        (b_y),
        .b_color    (b_color),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .VGA_x      (VGA_x),
        .VGA_y      (VGA_y),
        .VGA_color  (VGA_color),
        .VGA_write  (VGA_write),
        .drop_count (drop_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Resetn  = 1'b0;
        p_write = 1'b0; p_x = '0; p_y = '0; p_color = '0;
        b_valid = 1'b0; b_x = '0; b_y = '0; b_color = '0;
        a_valid = 1'b1; a_x = 10'd5; a_y = 9'd6; a_color = 9'h1AA;

        // reset with A requesting
        tick();
        tick();
        chk("rst_write", 32'(VGA_write), 32'(0));
        chk("rst_a_ready", 32'(a_ready), 32'(0));
        chk("rst_b_ready", 32'(b_ready), 32'(0));
        chk("rst_x", 32'(VGA_x), 32'(0));
        chk("rst_drop", 32'(drop_count), 32'(0));

        Resetn = 1'b1;
        #1;
        chk("rel_a_ready", 32'(a_ready), 32'(1));
        tick();
        chk("rel_write", 32'(VGA_write), 32'(1));
        chk("rel_x", 32'(VGA_x), 32'(5));
        chk("rel_y", 32'(VGA_y), 32'(6));
        chk("rel_color", 32'(VGA_color), 32'h1AA);

        // player burst starves both clients; B data wanders meanwhile
        a_x = 10'd20; a_y = 9'd30; a_color = 9'h011;
        b_x = 10'd40; b_y = 9'd50;
        a_valid = 1'b1; b_valid = 1'b1;
        p_write = 1'b1; p_x = 10'd150; p_y = 9'd360;
        for (int i = 0; i < 3600; i++) begin
            col = 9'(i);
            p_color = col;
            b_color = 9'(i * 7);
            #1;
            chk("burst_a_ready", 32'(a_ready), 32'(0));
            chk("burst_b_ready", 32'(b_ready), 32'(0));
            tick();
            chk("burst_write", 32'(VGA_write), 32'(1));
            chk("burst_color", 32'(VGA_color), 32'(col));
            chk("burst_x", 32'(VGA_x), 32'(150));
            chk("burst_y", 32'(VGA_y), 32'(360));
        end

        // A was served last, so B wins the first tie after the burst
        p_write = 1'b0;
        b_color = 9'h055;
        #1;
        chk("resume_b_ready", 32'(b_ready), 32'(1));
        chk("resume_a_ready", 32'(a_ready), 32'(0));
        tick();
        chk("resume_write", 32'(VGA_write), 32'(1));
        chk("resume_color", 32'(VGA_color), 32'h055);
        chk("resume_x", 32'(VGA_x), 32'(40));

        // both valid: strict alternation starting with A
        for (int k = 0; k < 8; k++) begin
            a_color = 9'(256 + k);
            b_color = 9'(128 + k);
            col = (k % 2 == 0) ? a_color : b_color;
            #1;
            chk("rr_a_ready", 32'(a_ready), 32'((k % 2) == 0));
            chk("rr_b_ready", 32'(b_ready), 32'((k % 2) == 1));
            if (a_ready) n_a++;
            if (b_ready) n_b++;
            tick();
            chk("rr_write", 32'(VGA_write), 32'(1));
            chk("rr_color", 32'(VGA_color), 32'(col));
            chk("rr_x", 32'(VGA_x), 32'((k % 2 == 0) ? 20 : 40));
        end
        chk("rr_count_a", 32'(n_a), 32'(4));
        chk("rr_count_b", 32'(n_b), 32'(4));

        // clipping at x=640 and y=480, then the last visible pixel
        b_valid = 1'b0;
        a_x = 10'd640; a_y = 9'd10; a_color = 9'h1FF;
        #1;
        chk("clipx_ready", 32'(a_ready), 32'(1));
        tick();
        chk("clipx_write", 32'(VGA_write), 32'(0));
        chk("clipx_drop", 32'(drop_count), 32'(1));
        chk("clipx_hold_x", 32'(VGA_x), 32'(40));
        a_x = 10'd10; a_y = 9'd480;
        #1;
        chk("clipy_ready", 32'(a_ready), 32'(1));
        tick();
        chk("clipy_write", 32'(VGA_write), 32'(0));
        chk("clipy_drop", 32'(drop_count), 32'(2));
        chk("clipy_hold_y", 32'(VGA_y), 32'(50));
        a_x = 10'd639; a_y = 9'd479; a_color = 9'h0F0;
        tick();
        chk("edge_write", 32'(VGA_write), 32'(1));
        chk("edge_x", 32'(VGA_x), 32'(639));
        chk("edge_y", 32'(VGA_y), 32'(479));
        chk("edge_drop", 32'(drop_count), 32'(2));

        // idle: strobe drops, coordinates hold
        a_valid = 1'b0;
        #1;
        chk("idle_a_ready", 32'(a_ready), 32'(0));
        tick();
        chk("idle_write", 32'(VGA_write), 32'(0));
        chk("idle_x", 32'(VGA_x), 32'(639));
        chk("idle_color", 32'(VGA_color), 32'h0F0);

        // saturate drop_count with clipped player writes
        p_write = 1'b1; p_x = 10'd700; p_y = 9'd0;
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (i == 65531) begin
                chk("sat_pre", 32'(drop_count), 32'hFFFE);
            end
        end
        chk("sat_drop", 32'(drop_count), 32'hFFFF);
        chk("sat_write", 32'(VGA_write), 32'(0));

        // reset while A requests: no ready, state cleared
        p_write = 1'b0;
        a_valid = 1'b1; a_x = 10'd1; a_y = 9'd1;
        Resetn = 1'b0;
        #1;
        chk("rst2_a_ready", 32'(a_ready), 32'(0));
        tick();
        chk("rst2_drop", 32'(drop_count), 32'(0));
        chk("rst2_write", 32'(VGA_write), 32'(0));
        chk("rst2_x", 32'(VGA_x), 32'(0));
        Resetn  = 1'b1;
        a_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
